// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its round-robin picker.
package uart_tx_arbiter_pkg;

    // Default payload width of the UART transmitter.
    localparam int unsigned ARB_DATA_WIDTH = 8;

    // Default number of requesters sharing the transmitter.
    localparam int unsigned ARB_NUM_REQ = 2;

    // Arbiter FSM: IDLE waits for a request, LOCKED owns the transmitter
    // until the granted requester completes a byte marked last.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the winner is the first
// requesting index found scanning upward from ptr+1 with wrap-around.
module rr_picker
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = ARB_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               any
);

    int unsigned slot;

    // Walk priority slots 1..NUM_REQ after ptr; ptr+k is wrapped by one
    // conditional subtract since ptr < NUM_REQ and k <= NUM_REQ.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        slot       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            slot = 32'(ptr) + k;
            if (slot >= NUM_REQ) begin
                slot = slot - NUM_REQ;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!any && req[i] && (slot == i)) begin
                    any        = 1'b1;
                    winner[i]  = 1'b1;
                    winner_idx = PTR_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmitter
// between NUM_REQ byte-stream requesters over ready/valid.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = ARB_NUM_REQ,
    parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int unsigned        PTR_W     = ptr_width(NUM_REQ);
    localparam logic [PTR_W-1:0]   PTR_RESET = PTR_W'(NUM_REQ - 1);

    arb_state_t           state, state_nxt;
    logic [NUM_REQ-1:0]   grant_q, grant_nxt;
    logic [PTR_W-1:0]     gidx_q, gidx_nxt;
    logic [PTR_W-1:0]     ptr_q, ptr_nxt;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_any;

    logic                 sel_last;
    logic                 handshake;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req        (req_valid),
        .ptr        (ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    // State, grant and round-robin pointer registers; reset puts the pointer
    // on the last requester so requester 0 has first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_RESET;
        end else begin
            state   <= state_nxt;
            grant_q <= grant_nxt;
            gidx_q  <= gidx_nxt;
            ptr_q   <= ptr_nxt;
        end
    end

    // Output mux steered by the one-hot grant; an all-zero grant (IDLE or
    // reset) drives zero data, no valid and no ready.
    always_comb begin
        tx_data  = '0;
        tx_valid = 1'b0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                tx_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                tx_valid = req_valid[i];
                sel_last = req_last[i];
            end
        end
        req_ready = grant_q & {NUM_REQ{tx_ready}};
        handshake = tx_valid & tx_ready;
    end

    // Next-state logic: arbitrate in IDLE, hold the grant in LOCKED until
    // the owner's last byte is accepted, then record it as the last winner.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        gidx_nxt  = gidx_q;
        ptr_nxt   = ptr_q;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_nxt = ARB_LOCKED;
                    grant_nxt = pick_onehot;
                    gidx_nxt  = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if (handshake && sel_last) begin
                    state_nxt = ARB_IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = gidx_q;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state == ARB_LOCKED);

endmodule
